// File: rtl/perf_counter_ctrl.sv
// Memory-mapped performance-counter controller for the MEM-stage data port.
// Claims accesses to WINDOW_BASE..16'hFFFF, runs a three-state read/write
// handshake, and owns five 16-bit saturating event counters with a global
// enable, a clear-all action and sticky overflow flags.
//
// Handshake: a request (mem_read or mem_write) is held by the pipeline until
// cpu_resp. The controller samples it in IDLE, performs it in ACCESS and
// pulses cpu_resp for exactly one cycle in RESP, with cpu_rdata valid in that
// same cycle. A request still high in the following IDLE cycle is a new access.
module perf_counter_ctrl #(
    parameter logic [15:0] WINDOW_BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    input  logic        load_pc,
    input  logic        br_valid,
    input  logic        mispredict,
    output logic        sel_counter,
    output logic        cpu_resp,
    output logic [15:0] cpu_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Counter order matches the OVF bit order in CTRL[15:11].
    localparam int NUM_CNT  = 5;
    localparam int CNT_CYC  = 0;
    localparam int CNT_INS  = 1;
    localparam int CNT_BR   = 2;
    localparam int CNT_MIS  = 3;
    localparam int CNT_STL  = 4;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;          // word index within the window
    logic        wr_q, wr_d;
    logic [6:0]  cwdata_q, cwdata_d;    // {wdata[15:11], wdata[1:0]}
    logic [1:0]  be_q, be_d;
    logic        resp_q, resp_d;
    logic [15:0] rdata_q, rdata_d;

    logic                          enable_q, enable_d;
    logic [NUM_CNT-1:0]            ovf_q, ovf_d;
    logic [NUM_CNT-1:0][15:0]      cnt_q, cnt_d;

    logic [NUM_CNT-1:0] event_vec;
    logic [NUM_CNT-1:0] clr_vec;
    logic [NUM_CNT-1:0] sat_hit;
    logic               access_wr;
    logic               ctrl_wr;
    logic               clear_all;
    logic [15:0]        reg_rdata;

    // Address bit 0 and the unused CTRL data bits have no function here.
    logic unused_bits;
    assign unused_bits = ^{mem_address[0], mem_wdata[10:2]};

    assign cpu_resp  = resp_q;
    assign cpu_rdata = rdata_q;
    assign dbg_state = state_q;

    // Claim decode, purely combinational so the read-data mux switches at once.
    always_comb begin
        sel_counter = (mem_read | mem_write) && (mem_address >= WINDOW_BASE);
    end

    // Event qualification, write decode and register read mux.
    always_comb begin
        event_vec          = '0;
        event_vec[CNT_CYC] = 1'b1;
        event_vec[CNT_INS] = load_pc;
        event_vec[CNT_BR]  = load_pc & br_valid;
        event_vec[CNT_MIS] = mispredict;
        event_vec[CNT_STL] = ~load_pc;
        event_vec          = event_vec & {NUM_CNT{enable_q}};

        access_wr = (state_q == ST_ACCESS) && wr_q;
        ctrl_wr   = access_wr && (idx_q == 3'd0);
        clear_all = ctrl_wr && be_q[0] && cwdata_q[1];

        clr_vec = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            clr_vec[i] = clear_all || (access_wr && (idx_q == 3'(i + 1)));
        end

        case (idx_q)
            3'd0:    reg_rdata = {ovf_q, 9'd0, 1'b0, enable_q};
            3'd1:    reg_rdata = cnt_q[CNT_CYC];
            3'd2:    reg_rdata = cnt_q[CNT_INS];
            3'd3:    reg_rdata = cnt_q[CNT_BR];
            3'd4:    reg_rdata = cnt_q[CNT_MIS];
            3'd5:    reg_rdata = cnt_q[CNT_STL];
            default: reg_rdata = 16'd0;
        endcase
    end

    // Counter bank next state: saturating increment, clears win over increments,
    // overflow set wins over a same-edge W1C.
    always_comb begin
        cnt_d    = cnt_q;
        sat_hit  = '0;
        enable_d = enable_q;
        ovf_d    = ovf_q;

        for (int i = 0; i < NUM_CNT; i++) begin
            if (event_vec[i]) begin
                if (cnt_q[i] == 16'hFFFF) begin
                    sat_hit[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 16'd1;
                end
            end
            if (clr_vec[i]) begin
                cnt_d[i] = 16'd0;
            end
        end

        if (ctrl_wr && be_q[0]) begin
            enable_d = cwdata_q[0];
        end
        if (ctrl_wr && be_q[1]) begin
            ovf_d = ovf_d & ~cwdata_q[6:2];
        end
        ovf_d = ovf_d | sat_hit;
    end

    // Handshake FSM next state, request capture and response/read-data staging.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        cwdata_d = cwdata_q;
        be_d     = be_q;
        resp_d   = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_counter) begin
                    idx_d    = mem_address[3:1];
                    wr_d     = mem_write;   // read+write together is a write
                    cwdata_d = {mem_wdata[15:11], mem_wdata[1:0]};
                    be_d     = mem_byte_enable;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                resp_d  = 1'b1;
                if (!wr_q) begin
                    rdata_d = reg_rdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and handshake registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            wr_q     <= 1'b0;
            cwdata_q <= 7'd0;
            be_q     <= 2'd0;
            resp_q   <= 1'b0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            cwdata_q <= cwdata_d;
            be_q     <= be_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
        end
    end

    // Counter bank, enable and sticky overflow flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            enable_q <= 1'b1;
            ovf_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed testbench for perf_counter_ctrl. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_perf_counter_ctrl;

    logic        clk;
    logic        reset_n;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        load_pc;
    logic        br_valid;
    logic        mispredict;
    logic        sel_counter;
    logic        cpu_resp;
    logic [15:0] cpu_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    perf_counter_ctrl #(.WINDOW_BASE(16'hFFF0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .load_pc         (load_pc),
        .br_valid        (br_valid),
        .mispredict      (mispredict),
        .sel_counter     (sel_counter),
        .cpu_resp        (cpu_resp),
        .cpu_rdata       (cpu_rdata),
        .dbg_state       (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access. Entered just after a rising edge; returns just after
    // the rising edge that follows one idle cycle after the response.
    task automatic do_access(input logic [15:0] addr, input logic wr,
                             input logic [15:0] wdata, input logic [1:0] be,
                             output logic [15:0] rdata);
        bit got;
        got             = 1'b0;
        rdata           = 16'd0;
        mem_address     = addr;
        mem_write       = wr;
        mem_read        = ~wr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (cpu_resp) begin
                got   = 1'b1;
                rdata = cpu_rdata;
            end
            @(posedge clk); #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check_eq("resp_seen", {15'd0, got}, 16'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        do_access(addr, 1'b0, 16'd0, 2'b00, d);
        check_eq(tag, d, exp);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
        logic [15:0] d;
        do_access(addr, 1'b1, wdata, be, d);
    endtask

    initial begin
        int nresp;
        logic [1:0] exp_st [6];
        exp_st = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        reset_n = 1'b0; mem_address = 16'd0; mem_read = 1'b0; mem_write = 1'b0;
        mem_wdata = 16'd0; mem_byte_enable = 2'b00;
        load_pc = 1'b0; br_valid = 1'b0; mispredict = 1'b0;

        // Reset state, then 10 retired instructions
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("rst_resp",  {15'd0, cpu_resp}, 16'd0);
        check_eq("rst_rdata", cpu_rdata, 16'd0);
        check_eq("rst_state", {14'd0, dbg_state}, 16'd0);
        check_eq("rst_sel",   {15'd0, sel_counter}, 16'd0);
        @(posedge clk); #1;
        load_pc = 1'b1;
        repeat (10) @(posedge clk);
        #1 load_pc = 1'b0;
        rd_chk("instr_10", 16'hFFF4, 16'd10);
        rd_chk("ctrl_reset", 16'hFFF0, 16'h0001);

        // Branch and mispredict events
        load_pc = 1'b1; br_valid = 1'b1; mispredict = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        mispredict = 1'b0;
        @(posedge clk); #1;
        load_pc = 1'b0; br_valid = 1'b0;
        rd_chk("branch_3", 16'hFFF6, 16'd3);
        rd_chk("mispred_2", 16'hFFF8, 16'd2);

        // Clear beats increment; cycle counter restarts from 0
        wr(16'hFFF2, 16'h0000, 2'b11);
        rd_chk("cycle_after_clr", 16'hFFF2, 16'd3);

        // Read handshake with request held for two accesses
        wr(16'hFFF2, 16'h0000, 2'b11);
        mem_address = 16'hFFF2; mem_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("hs_sel_%0d", k), {15'd0, sel_counter}, 16'd1);
            check_eq($sformatf("hs_resp_%0d", k), {15'd0, cpu_resp},
                     (k == 2 || k == 5) ? 16'd1 : 16'd0);
            check_eq($sformatf("hs_state_%0d", k), {14'd0, dbg_state}, {14'd0, exp_st[k]});
            if (k == 2) check_eq("hs_rdata_1", cpu_rdata, 16'd3);
            if (k == 5) check_eq("hs_rdata_2", cpu_rdata, 16'd6);
            @(posedge clk); #1;
        end
        mem_read = 1'b0;

        // Stall counter saturation
        wr(16'hFFFA, 16'h0000, 2'b11);
        repeat (65540) @(posedge clk);
        #1;
        rd_chk("stall_sat", 16'hFFFA, 16'hFFFF);
        rd_chk("ctrl_ovf", 16'hFFF0, 16'h8801);

        // W1C of OVF; a same-edge overflow keeps its bit set
        load_pc = 1'b1;
        wr(16'hFFF0, 16'h8001, 2'b11);
        rd_chk("ctrl_w1c", 16'hFFF0, 16'h0801);
        wr(16'hFFF0, 16'h0800, 2'b10);
        rd_chk("ctrl_w1c_vs_set", 16'hFFF0, 16'h0801);

        // CLEAR_ALL
        wr(16'hFFF0, 16'h0003, 2'b11);
        rd_chk("clrall_cycle",   16'hFFF2, 16'd3);
        rd_chk("clrall_instr",   16'hFFF4, 16'd7);
        rd_chk("clrall_branch",  16'hFFF6, 16'd0);
        rd_chk("clrall_mispred", 16'hFFF8, 16'd0);
        rd_chk("clrall_stall",   16'hFFFA, 16'd0);

        // High byte only: ENABLE untouched, OVF cleared
        wr(16'hFFF0, 16'h0800, 2'b10);
        rd_chk("ctrl_be_hi", 16'hFFF0, 16'h0001);

        // Low byte: disable, takes effect from the next edge
        wr(16'hFFF2, 16'h0000, 2'b11);
        wr(16'hFFF0, 16'h0000, 2'b01);
        rd_chk("frozen_cycle_a", 16'hFFF2, 16'd4);
        rd_chk("frozen_cycle_b", 16'hFFF2, 16'd4);
        rd_chk("frozen_instr_a", 16'hFFF4, 16'd36);
        rd_chk("ctrl_disabled", 16'hFFF0, 16'h0000);

        // Reserved addresses; read data held across a write
        rd_chk("rsv_read", 16'hFFFC, 16'h0000);
        rd_chk("frozen_instr_b", 16'hFFF4, 16'd36);
        wr(16'hFFFE, 16'hFFFF, 2'b11);
        check_eq("rdata_hold", cpu_rdata, 16'd36);
        rd_chk("ctrl_after_rsv", 16'hFFF0, 16'h0000);

        // Reset in the middle of a write to INSTR
        load_pc = 1'b0;
        wr(16'hFFF0, 16'h0001, 2'b01);
        wr(16'hFFF4, 16'h0000, 2'b11);
        load_pc = 1'b1;
        repeat (5) @(posedge clk);
        #1 load_pc = 1'b0;
        rd_chk("instr_5", 16'hFFF4, 16'd5);
        mem_address = 16'hFFF4; mem_write = 1'b1; mem_wdata = 16'h0000; mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mid_state", {14'd0, dbg_state}, 16'd1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_resp",  {15'd0, cpu_resp}, 16'd0);
        check_eq("abort_state", {14'd0, dbg_state}, 16'd0);
        check_eq("abort_rdata", cpu_rdata, 16'd0);
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        nresp = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_resp) nresp++;
        end
        check_eq("no_resp_after_rst", 16'(nresp), 16'd0);
        @(posedge clk); #1;
        rd_chk("instr_after_rst", 16'hFFF4, 16'd0);
        rd_chk("ctrl_after_rst", 16'hFFF0, 16'h0001);

        // Out-of-window requests
        mem_address = 16'h1000; mem_read = 1'b1;
        nresp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("oow_sel_%0d", k), {15'd0, sel_counter}, 16'd0);
            if (cpu_resp) nresp++;
            @(posedge clk); #1;
        end
        check_eq("oow_no_resp", 16'(nresp), 16'd0);
        mem_address = 16'hFFEF;
        #1 check_eq("sel_below_base", {15'd0, sel_counter}, 16'd0);
        mem_address = 16'hFFF0;
        #1 check_eq("sel_at_base", {15'd0, sel_counter}, 16'd1);
        mem_read = 1'b0;
        #1 check_eq("sel_no_req", {15'd0, sel_counter}, 16'd0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

Memory-mapped performance-counter controller for the LC-3b pipeline's MEM-stage data port. It decodes accesses to the I/O window 0xFFF0–0xFFFF and runs the read/write handshake for them. It owns and sequences a bank of five 16-bit saturating event counters, with global enable/clear and sticky overflow flags. It sits beside the data cache: when it claims an access, the MEM-stage read-data mux selects it instead of the cache.

## Interface
Parameters:
- WINDOW_BASE, 16'hFFF0, lowest claimed address; window is WINDOW_BASE..16'hFFFF.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- mem_address  in  16  MEM-stage byte address; bit 0 ignored for decode
- mem_read  in  1  read request, held until cpu_resp
- mem_write  in  1  write request, held until cpu_resp
- mem_wdata  in  16  write data
- mem_byte_enable  in  2  [0] low byte, [1] high byte
- load_pc  in  1  PC advance (instruction retired)
- br_valid  in  1  retiring instruction is a branch (qualified with load_pc)
- mispredict  in  1  one-cycle mispredict pulse
- sel_counter  out  1  access is claimed; steers the MEM read-data mux
- cpu_resp  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid while cpu_resp=1

## Operation
- Register map (word addresses):
  - 0xFFF0: CTRL.
    - bit0 ENABLE, reset 1.
    - bit1 CLEAR_ALL, write-1 action, reads 0.
    - bits15:11 OVF flags, sticky, W1C. Order: 11 CYCLE, 12 INSTR, 13 BRANCH, 14 MISPRED, 15 STALL.
    - Other bits read 0.
  - 0xFFF2 CYCLE, 0xFFF4 INSTR, 0xFFF6 BRANCH, 0xFFF8 MISPRED, 0xFFFA STALL.
  - 0xFFFC and 0xFFFE are reserved: reads return 0, writes are ignored, and the access still completes.
- Counter events apply only while ENABLE=1:
  - CYCLE: every cycle.
  - INSTR: load_pc.
  - BRANCH: load_pc && br_valid.
  - MISPRED: mispredict.
  - STALL: !load_pc.
- Saturation: a counter at 16'hFFFF stays there when its event fires and sets its OVF bit on that edge.
- A write to a counter address clears that counter to 0. mem_wdata and mem_byte_enable are ignored for counter writes.
- CTRL writes:
  - If mem_byte_enable[0]: ENABLE <= wdata[0]; if wdata[1]=1, all counters go to 0.
  - If mem_byte_enable[1]: OVF &= ~wdata[15:11].
- Reads return the full 16-bit word; the pipeline does byte selection.
- sel_counter is combinational: (mem_read | mem_write) && mem_address >= WINDOW_BASE.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE: when sel_counter=1, latch the address, read/write flag and data, then go to ACCESS.
  - ACCESS: perform the write, or load cpu_rdata from the addressed register as held during this cycle. Go to RESP.
  - RESP: cpu_resp=1, then return to IDLE. A request still high in the following IDLE cycle is treated as a new access.
- If mem_read and mem_write are both high, the access is a write.
- Collision rules:
  - A clear (per-counter, CLEAR_ALL, or reset) beats a same-edge increment; the counter ends at 0.
  - A W1C on an OVF bit loses to a same-edge overflow set; the bit stays 1.
  - A CTRL write that sets ENABLE=0 takes effect starting with the next edge's increments.

## Timing
- Reset values: every counter 0, OVF 0, ENABLE 1, state IDLE, cpu_resp 0, cpu_rdata 0.
- sel_counter is combinational from its inputs and has no reset dependence.
- Latency:
  - Request first seen in IDLE at cycle 0.
  - ACCESS in cycle 1.
  - cpu_resp=1 in cycle 2, with cpu_rdata valid in the same cycle.
  - Next access can start in cycle 3.
- cpu_rdata holds its value until the next read completes.
- Read data reflects all events through cycle 0, i.e. the value the counter holds during ACCESS. Counters keep counting during ACCESS and RESP, including the counter being read.
- Reset asserted in any state aborts immediately: no write is committed and cpu_resp drops at once. The pipeline reissues the access after reset.
- Out-of-window requests never leave IDLE and never assert cpu_resp.

## Test plan
- Reset then idle: release reset_n and run 10 cycles with load_pc=1. Then read 0xFFF4 and expect 10 (the INSTR count); read 0xFFF0 and expect 16'h0001.
- Read handshake: hold mem_read at 0xFFF2 from cycle 0. Expect sel_counter=1 in cycles 0–2; cpu_resp=1 only in cycle 2; cpu_rdata = CYCLE value as of cycle 1. With the request still held, the next cpu_resp arrives in cycle 5.
- Saturation and W1C:
  - Preload STALL to 16'hFFFE. After 3 stall cycles, read 0xFFFA and expect 16'hFFFF; CTRL[15]=1.
  - Write 0xFFF0 with 16'h8001 and byte_enable 2'b11; expect CTRL[15]=0.
- Clear vs increment: write 0xFFF2 while ENABLE=1. Read it back and expect CYCLE = 3 at the read's RESP (cleared at end of the write's ACCESS, then counting cycles). CLEAR_ALL (write 16'h0003) zeroes all five counters.
- Disable with partial byte enable: write 0xFFF0 with 16'h0000 and byte_enable 2'b10; ENABLE stays 1. Repeat with 2'b01; all counters freeze, and a later read returns the same values twice.
- Reset mid-access: assert reset_n=0 during the ACCESS of a write to 0xFFF4 (INSTR=5). Expect cpu_resp=0 at once and INSTR=0, with no resp pulse until a new request arrives; out-of-window address 0x1000 produces no sel_counter and no cpu_resp.
